// File: rtl/seg_scan_if.sv
// Control and display signals between the scan controller and its host/display.
interface seg_scan_if;
  logic        en;
  logic        load;
  logic [31:0] data;
  logic [7:0]  dp;
  logic [7:0]  blank;
  logic [2:0]  sel;
  logic [6:0]  seg;
  logic        dp_n;
  logic        tick;

  modport master (
    output en, load, data, dp, blank,
    input  sel, seg, dp_n, tick
  );

  modport slave (
    input  en, load, data, dp, blank,
    output sel, seg, dp_n, tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: prescaled digit index plus
// registered hex segment patterns from a double-buffered display word.
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV        = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  io_scan
);

  localparam int unsigned CNT_W    = $clog2(CLK_DIV);
  localparam logic [6:0]  SEG_DARK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic        DP_DARK  = SEG_ACTIVE_LOW;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
  } frame_t;

  localparam frame_t FRAME_RST = {32'h0, 8'h00, 8'hFF};

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic             r_tick;
  logic [6:0]       r_seg;
  logic             r_dp_n;
  frame_t           r_pend;
  frame_t           r_act;

  logic             w_term;
  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_sel_nxt;
  frame_t           w_pend_nxt;
  frame_t           w_act_nxt;
  logic [3:0]       w_nib;
  logic [6:0]       w_hex;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_n_nxt;

  // Prescaler, digit index and buffer commit
  always_comb begin
    w_term     = io_scan.en && (r_cnt == CNT_W'(CLK_DIV - 1));
    w_wrap     = w_term && (r_sel == 3'd7);
    w_cnt_nxt  = r_cnt;
    if (io_scan.en) begin
      w_cnt_nxt = w_term ? '0 : r_cnt + CNT_W'(1);
    end
    w_sel_nxt  = w_term ? r_sel + 3'd1 : r_sel;
    w_pend_nxt = io_scan.load ? frame_t'({io_scan.data, io_scan.dp, io_scan.blank}) : r_pend;
    // Commit samples the pending value from before this edge, so a coincident load waits a frame
    w_act_nxt  = w_wrap ? r_pend : r_act;
  end

  // Pattern is derived from next-state sel/buffer so it lands on the same edge as sel
  always_comb begin
    w_nib = w_act_nxt.data[{w_sel_nxt, 2'b00} +: 4];
    w_hex = 7'h00;
    case (w_nib)
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      4'hF: w_hex = 7'h71;
      default: w_hex = 7'h00;
    endcase

    w_seg_nxt  = SEG_DARK;
    w_dp_n_nxt = DP_DARK;
    if (io_scan.en && !w_act_nxt.blank[w_sel_nxt]) begin
      w_seg_nxt  = SEG_ACTIVE_LOW ? ~w_hex : w_hex;
      w_dp_n_nxt = SEG_ACTIVE_LOW ? ~w_act_nxt.dp[w_sel_nxt] : w_act_nxt.dp[w_sel_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sel  <= 3'd0;
      r_tick <= 1'b0;
      r_seg  <= SEG_DARK;
      r_dp_n <= DP_DARK;
      r_pend <= FRAME_RST;
      r_act  <= FRAME_RST;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sel  <= w_sel_nxt;
      r_tick <= w_term;
      r_seg  <= w_seg_nxt;
      r_dp_n <= w_dp_n_nxt;
      r_pend <= w_pend_nxt;
      r_act  <= w_act_nxt;
    end
  end

  assign io_scan.sel  = r_sel;
  assign io_scan.seg  = r_seg;
  assign io_scan.dp_n = r_dp_n;
  assign io_scan.tick = r_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with CLK_DIV=4, active-low segments.
module tb_seg_scan_ctrl;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  p;
    logic [7:0]  b;
  } buf_t;

  localparam buf_t BUF_RST = {32'h0, 8'h00, 8'hFF};
  localparam buf_t L2  = {32'h76543210, 8'h00, 8'h00};
  localparam buf_t L3  = {32'h76543210, 8'h04, 8'h80};
  localparam buf_t L4A = {32'h89ABCDEF, 8'hFF, 8'h00};
  localparam buf_t L4B = {32'hFEDCBA98, 8'h00, 8'h00};
  localparam buf_t L6  = {32'h13579BDF, 8'h01, 8'h00};

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [10:0] exp_q [$];
  logic [2:0]  exp_sel;
  buf_t        exp_pend;
  buf_t        exp_act;

  seg_scan_if bus ();

  seg_scan_ctrl #(.CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_scan (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected {sel, seg, dp_n} for digit s of buffer f
  function automatic logic [10:0] expect_slot(input logic [2:0] s, input buf_t f);
    logic [31:0] d;
    logic [3:0]  nib;
    d   = f.d >> (4 * s);
    nib = d[3:0];
    if (f.b[s]) return {s, 7'h7F, 1'b1};
    return {s, ~hex_tab[nib], ~f.p[s]};
  endfunction

  // Monitor: every tick presents a new digit slot
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.tick === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_tick", 64'd1, 64'd0);
      else check("slot", 64'({bus.sel, bus.seg, bus.dp_n}), 64'(exp_q.pop_front()));
    end
  end

  task automatic pause_scan();
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pause_sel",  64'(bus.sel), 64'(exp_sel));
      check("pause_tick", 64'(bus.tick), 64'd0);
      check("pause_dark", 64'({bus.seg, bus.dp_n}), 64'({7'h7F, 1'b1}));
    end
    bus.en = 1'b1;
  endtask

  // One 4-clock digit slot, starting at a negedge with the prescaler at 0
  task automatic slot(input bit do_load, input int lphase, input buf_t ld, input int pphase);
    logic [2:0] sel_n;
    buf_t       pend_eff;
    sel_n    = exp_sel + 3'd1;
    pend_eff = (do_load && lphase < 4) ? ld : exp_pend;
    if (exp_sel == 3'd7) exp_act = pend_eff;
    exp_q.push_back(expect_slot(sel_n, exp_act));
    if (do_load) exp_pend = ld;
    for (int k = 1; k <= 4; k++) begin
      if (do_load && k == lphase) begin
        bus.load  = 1'b1;
        bus.data  = ld.d;
        bus.dp    = ld.p;
        bus.blank = ld.b;
      end
      @(negedge clk);
      bus.load = 1'b0;
      check("tick_timing", 64'(bus.tick), 64'(k == 4));
      if (k == pphase) pause_scan();
    end
    exp_sel = sel_n;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) slot(1'b0, 0, BUF_RST, 0);
  endtask

  task automatic check_reset_state(input string name);
    check(name, 64'({bus.sel, bus.seg, bus.dp_n, bus.tick}), 64'({3'd0, 7'h7F, 1'b1, 1'b0}));
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.en    = 1'b0;
    bus.load  = 1'b0;
    bus.data  = 32'h0;
    bus.dp    = 8'h0;
    bus.blank = 8'h0;
    exp_sel   = 3'd0;
    exp_pend  = BUF_RST;
    exp_act   = BUF_RST;
    repeat (3) @(negedge clk);
    check_reset_state("reset_state");
    rst_n  = 1'b1;
    bus.en = 1'b1;

    // Dark scan through a full frame and the first wrap
    run(8);
    // Mid-frame load held back until the wrap
    run(3);
    slot(1'b1, 2, L2, 0);
    run(4);
    // Decimal point and blanked digit
    run(2);
    slot(1'b1, 1, L3, 0);
    run(5);
    run(8);
    // Load landing exactly on the wrap edge
    run(1);
    slot(1'b1, 3, L4A, 0);
    run(5);
    slot(1'b1, 4, L4B, 0);
    run(8);
    run(8);
    // Freeze at sel=5, count=2
    run(5);
    slot(1'b0, 0, BUF_RST, 2);
    run(2);
    // Asynchronous reset mid-frame
    run(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    check_reset_state("reset_hold");
    rst_n    = 1'b1;
    exp_sel  = 3'd0;
    exp_pend = BUF_RST;
    exp_act  = BUF_RST;
    run(9);
    slot(1'b1, 1, L6, 0);
    run(6);
    run(8);

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
